// File: rtl/xs3_bcd_packer.sv
// xs3_bcd_packer: decodes a stream of Excess-3 digits into BCD and packs
// DIGITS of them, first-received in the top nibble, into one output word
// delivered over a valid/ready handshake. Bad codes decode as 0 and set a
// sticky error flag that travels with the word.
module xs3_bcd_packer #(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            in_xs3,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   out_word,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            digit_cnt
);

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

  localparam int         W        = 4 * DIGITS;
  localparam logic [3:0] LAST_IDX = 4'(DIGITS - 1);
  localparam logic [3:0] FULL_CNT = 4'(DIGITS);

  state_t         state_q, state_d;
  logic [W-1:0]   word_q, word_d;
  logic           err_q, err_d;
  logic [3:0]     cnt_q, cnt_d;

  // Per-digit decode: legal XS3 codes are 3..12; anything else becomes 0.
  logic           code_ok;
  logic [3:0]     bcd;
  logic [W-1:0]   word_shifted;

  assign code_ok = (in_xs3 >= 4'd3) && (in_xs3 <= 4'd12);
  assign bcd     = code_ok ? (in_xs3 - 4'd3) : 4'h0;

  // The new digit enters the bottom nibble so the first digit ends on top.
  generate
    if (DIGITS == 1) begin : g_single
      assign word_shifted = bcd;
    end else begin : g_multi
      assign word_shifted = {word_q[W-5:0], bcd};
    end
  endgenerate

  // State and datapath registers; reset discards any partial or pending word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= COLLECT;
      word_q  <= '0;
      err_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: collect DIGITS digits, then hold until accepted.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      COLLECT: begin
        if (in_valid) begin
          word_d = word_shifted;
          err_d  = err_q | ~code_ok;
          cnt_d  = cnt_q + 4'd1;
          if (cnt_q == LAST_IDX) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Word stays visible after acceptance; shifting overwrites it later.
        if (out_ready) begin
          state_d = COLLECT;
          cnt_d   = 4'd0;
          err_d   = 1'b0;
        end
      end
      default: begin
        state_d = COLLECT;
      end
    endcase
  end

  assign in_ready  = (state_q == COLLECT);
  assign out_valid = (state_q == HOLD);
  assign out_word  = word_q;
  assign out_err   = err_q;
  assign digit_cnt = cnt_q;

  // Count never exceeds DIGITS: HOLD is entered exactly on the last digit.
  logic unused_full;
  assign unused_full = (FULL_CNT == 4'd0);

endmodule

// File: tb/tb_xs3_bcd_packer.sv
// Testbench for xs3_bcd_packer (DIGITS=4): table-driven words, hand-written
// handshake corner cases and a randomized run against a queue-based model.
module tb_xs3_bcd_packer;

  localparam int DIGITS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  in_xs3;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] out_word;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  digit_cnt;

  int checks = 0;
  int errors = 0;

  xs3_bcd_packer #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_xs3    (in_xs3),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_word  (out_word),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .digit_cnt (digit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] codes;  // four XS3 codes, first-sent in the top nibble
    logic [15:0] word;
    logic        err;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one code and wait (bounded) for it to be taken; returns at the
  // negedge after the accepting edge.
  task automatic send_digit(input logic [3:0] code);
    int tries = 0;
    while (!in_ready && tries < 20) begin
      @(negedge clk);
      tries++;
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    in_xs3   = code;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_word(input logic [15:0] codes);
    for (int i = 3; i >= 0; i--) begin
      logic [15:0] c;
      c = codes >> (4 * i);
      send_digit(c[3:0]);
    end
  endtask

  // Reference model: plain arithmetic over the accepted digit stream.
  int          m_cnt;
  bit          m_hold;
  int unsigned m_word;
  bit          m_err;

  function automatic int unsigned xs3_value(input int code);
    return (code >= 3 && code <= 12) ? code - 3 : 0;
  endfunction

  initial begin
    vecs[0] = '{codes: 16'h456C, word: 16'h1239, err: 1'b0};
    vecs[1] = '{codes: 16'h32B7, word: 16'h0084, err: 1'b1};
    vecs[2] = '{codes: 16'h3333, word: 16'h0000, err: 1'b0};
    vecs[3] = '{codes: 16'h0123, word: 16'h0000, err: 1'b1};
    vecs[4] = '{codes: 16'h4567, word: 16'h1234, err: 1'b0};
    vecs[5] = '{codes: 16'h89AB, word: 16'h5678, err: 1'b0};
    vecs[6] = '{codes: 16'hCDEF, word: 16'h9000, err: 1'b1};
    vecs[7] = '{codes: 16'hC3C3, word: 16'h9090, err: 1'b0};

    rst = 1'b1; in_xs3 = 4'h0; in_valid = 1'b0; out_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_word", out_word, 0);
    check("rst_out_err", out_err, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_digit_cnt", digit_cnt, 0);

    // Table: back-to-back words, out_ready high, 1-cycle latency and hold
    for (int v = 0; v < 8; v++) begin
      send_word(vecs[v].codes);
      check("tbl_out_valid", out_valid, 1);
      check("tbl_out_word", out_word, vecs[v].word);
      check("tbl_out_err", out_err, vecs[v].err);
      check("tbl_cnt_full", digit_cnt, 4);
      check("tbl_in_ready_hold", in_ready, 0);
      @(negedge clk);
      check("tbl_valid_drop", out_valid, 0);
      check("tbl_cnt_clear", digit_cnt, 0);
      check("tbl_err_clear", out_err, 0);
      check("tbl_word_kept", out_word, vecs[v].word);
      $display("word %0d codes=%h word=%h err=%0b", v, vecs[v].codes, out_word, vecs[v].err);
    end

    // Backpressure: word held while in_valid stays high
    out_ready = 1'b0;
    send_word(16'h789A);
    in_xs3 = 4'h8; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp_valid", out_valid, 1);
      check("bp_word", out_word, 16'h4567);
      check("bp_in_ready", in_ready, 0);
      check("bp_cnt", digit_cnt, 4);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", out_valid, 0);
    check("bp_release_cnt", digit_cnt, 0);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_next_accept_cnt", digit_cnt, 1);
    send_digit(4'h9); send_digit(4'hA); send_digit(4'hB);
    check("bp_next_word", out_word, 16'h5678);
    check("bp_next_valid", out_valid, 1);
    $display("backpressure word=%h", out_word);
    @(negedge clk);

    // Reset mid-word
    send_digit(4'h5); send_digit(4'h6);
    check("mid_cnt_before", digit_cnt, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_cnt", digit_cnt, 0);
    check("mid_valid", out_valid, 0);
    check("mid_word", out_word, 0);
    send_word(16'hCBA9);
    check("mid_fresh_word", out_word, 16'h9876);
    check("mid_fresh_err", out_err, 0);
    $display("reset mid-word fresh word=%h", out_word);

    // Randomized run against the model
    rst = 1'b1; in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    m_cnt = 0; m_hold = 0; m_word = 0; m_err = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      check("rnd_in_ready", in_ready, !m_hold);
      check("rnd_out_valid", out_valid, m_hold);
      check("rnd_digit_cnt", digit_cnt, m_cnt);
      check("rnd_out_word", out_word, m_word);
      check("rnd_out_err", out_err, m_err);
      if (m_hold && out_ready)
        $display("rnd cycle %0d word=%h err=%0b accepted", cyc, out_word, out_err);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_xs3    = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 2) != 0);
      if (!m_hold) begin
        if (in_valid) begin
          m_word = (m_word * 16 + xs3_value(int'(in_xs3))) % 65536;
          if (xs3_value(int'(in_xs3)) == 0 && in_xs3 != 4'h3) m_err = 1;
          m_cnt++;
          if (m_cnt == DIGITS) m_hold = 1;
        end
      end else if (out_ready) begin
        m_hold = 0;
        m_cnt  = 0;
        m_err  = 0;
      end
      @(negedge clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
